// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock,
// fixed 15-cycle latency from request acceptance to a registered 4-digit result.
module bin_to_bcd_seq #(
  parameter logic [15:0] OVF_CODE = 16'hEEEE
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [13:0] bin_value,
  input  logic        bin_valid,
  output logic        bin_ready,
  output logic [15:0] displayed_number,
  output logic        bcd_valid,
  output logic        overflow
);

  typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

  state_e      state_q;
  logic [13:0] shift_q;
  logic [15:0] scratch_q;
  logic [3:0]  count_q;
  logic        ovf_latched_q;
  logic [15:0] scratch_adj;

  // Add-3 correction applied to every nibble before the shift
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bin_ready = (state_q == StIdle);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      shift_q          <= '0;
      scratch_q        <= '0;
      count_q          <= '0;
      ovf_latched_q    <= 1'b0;
      displayed_number <= '0;
      bcd_valid        <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bin_valid) begin
            shift_q       <= bin_value;
            scratch_q     <= '0;
            count_q       <= '0;
            ovf_latched_q <= (bin_value > 14'd9999);
            state_q       <= StShift;
          end
        end
        StShift: begin
          {scratch_q, shift_q} <= {scratch_adj[14:0], shift_q, 1'b0};
          count_q              <= count_q + 4'd1;
          if (count_q == 4'd13) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          displayed_number <= ovf_latched_q ? OVF_CODE : scratch_q;
          overflow         <= ovf_latched_q;
          bcd_valid        <= 1'b1;
          state_q          <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
